multicycle_controller: RTL and testbench

//  Control FSM that sequences the shared datapath (PC, ROM/memory, decoder, register file, ALU, DataMemory).

---
 rtl/multicycle_controller_pkg.sv | 64 ++++++
 rtl/multicycle_controller_ctrl_outputs_decode.sv | 68 ++++++
 rtl/multicycle_controller.sv | 132 +++++++++++++
 tb/tb_multicycle_controller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// ALU/PC select codes and the packed control word.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_EXEC    = 4'd6,
    ST_RWB     = 4'd7,
    ST_ADDI_EX = 4'd8,
    ST_ADDI_WB = 4'd9,
    ST_BRANCH  = 4'd10,
    ST_JUMP    = 4'd11,
    ST_HALT    = 4'd12,
    ST_TRAP    = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALU_OP_ADD   = 2'd0;
  localparam logic [1:0] ALU_OP_SUB   = 2'd1;
  localparam logic [1:0] ALU_OP_FUNCT = 2'd2;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] ALUB_RT      = 2'd0;
  localparam logic [1:0] ALUB_FOUR    = 2'd1;
  localparam logic [1:0] ALUB_IMM     = 2'd2;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'd3;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_c;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       halted;
    logic       trap;
  } ctrl_word_t;

  function automatic logic is_wait_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_controller_ctrl_outputs_decode.sv
// Combinational state -> control-word lookup for the multicycle controller.
module ctrl_outputs_decode
  import multicycle_controller_pkg::*;
(
  input  state_t     state_i,
  input  logic       fetch_ack_i,
  output ctrl_word_t ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      ST_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = ALUB_FOUR;
        ctrl_o.alu_op    = ALU_OP_ADD;
        ctrl_o.ir_write  = fetch_ack_i;
        ctrl_o.pc_write  = fetch_ack_i;
      end
      ST_DECODE: begin
        ctrl_o.alu_src_b = ALUB_IMM_SH2;
        ctrl_o.alu_op    = ALU_OP_ADD;
      end
      ST_MEMADR, ST_ADDI_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUB_IMM;
        ctrl_o.alu_op    = ALU_OP_ADD;
      end
      ST_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      ST_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      ST_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUB_RT;
        ctrl_o.alu_op    = ALU_OP_FUNCT;
      end
      ST_RWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      ST_ADDI_WB: ctrl_o.reg_write = 1'b1;
      ST_BRANCH: begin
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_src_b  = ALUB_RT;
        ctrl_o.alu_op     = ALU_OP_SUB;
        ctrl_o.pc_src     = PC_SRC_ALUOUT;
        ctrl_o.pc_write_c = 1'b1;
      end
      ST_JUMP: begin
        ctrl_o.pc_src   = PC_SRC_JUMP;
        ctrl_o.pc_write = 1'b1;
      end
      ST_HALT: ctrl_o.halted = 1'b1;
      ST_TRAP: ctrl_o.trap   = 1'b1;
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback,
// handles memory-ready waits with timeout, halt requests and illegal-opcode traps.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             pc_write,
  output logic             pc_write_c,
  output logic [1:0]       pc_src,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_q;
  logic [7:0]       timer_q;
  logic [CNT_W-1:0] retired_q;

  logic       halt_take;
  logic       fetch_ack;
  logic       timed_out;
  ctrl_word_t ctrl_dec;
  ctrl_word_t ctrl;

  // zero is gated by the datapath through pc_write_c, not by the FSM
  logic unused_zero;
  assign unused_zero = zero;

  assign halt_take = (state_q == ST_FETCH) && (timer_q == '0) && halt_req;
  assign fetch_ack = mem_ready && !halt_take;
  assign timed_out = !mem_ready && (timer_q == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      timer_q   <= '0;
      retired_q <= '0;
    end else begin
      if (is_wait_state(state_q) && !mem_ready && !halt_take && !timed_out)
        timer_q <= timer_q + 8'd1;
      else
        timer_q <= '0;

      unique case (state_q)
        ST_FETCH: begin
          if (halt_take)      state_q <= ST_HALT;
          else if (mem_ready) state_q <= ST_DECODE;
          else if (timed_out) state_q <= ST_TRAP;
        end
        ST_DECODE: begin
          unique case (opcode)
            OP_RTYPE:     state_q <= ST_EXEC;
            OP_LW, OP_SW: state_q <= ST_MEMADR;
            OP_BEQ:       state_q <= ST_BRANCH;
            OP_J:         state_q <= ST_JUMP;
            OP_ADDI:      state_q <= ST_ADDI_EX;
            default:      state_q <= ST_TRAP;
          endcase
        end
        ST_MEMADR: state_q <= (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
        ST_MEMRD: begin
          if (mem_ready)      state_q <= ST_MEMWB;
          else if (timed_out) state_q <= ST_TRAP;
        end
        ST_MEMWR: begin
          if (mem_ready) begin
            state_q   <= ST_FETCH;
            retired_q <= retired_q + 1'b1;
          end else if (timed_out) begin
            state_q <= ST_TRAP;
          end
        end
        ST_EXEC:    state_q <= ST_RWB;
        ST_ADDI_EX: state_q <= ST_ADDI_WB;
        ST_MEMWB, ST_RWB, ST_ADDI_WB, ST_BRANCH, ST_JUMP: begin
          state_q   <= ST_FETCH;
          retired_q <= retired_q + 1'b1;
        end
        ST_HALT: if (!halt_req) state_q <= ST_FETCH;
        ST_TRAP: state_q <= ST_TRAP;
        default: state_q <= ST_TRAP;
      endcase
    end
  end

  ctrl_outputs_decode u_decode (
    .state_i     (state_q),
    .fetch_ack_i (fetch_ack),
    .ctrl_o      (ctrl_dec)
  );

  // Forcing the word low while reset is held keeps FETCH's read strobe quiet
  assign ctrl = reset ? ctrl_dec : '0;

  assign pc_write   = ctrl.pc_write;
  assign pc_write_c = ctrl.pc_write_c;
  assign pc_src     = ctrl.pc_src;
  assign i_or_d     = ctrl.i_or_d;
  assign ir_write   = ctrl.ir_write;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_dst    = ctrl.reg_dst;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign halted     = ctrl.halted;
  assign trap       = ctrl.trap;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
module tb_multicycle_controller;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        halt_req;
  logic        pc_write, pc_write_c, i_or_d, ir_write, mem_read, mem_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, halted, trap;
  logic [1:0]  pc_src, alu_src_b, alu_op;
  logic [31:0] retired;

  int checks;
  int failures;

  logic [17:0] word;
  assign word = {pc_write, pc_write_c, pc_src, i_or_d, ir_write, mem_read, mem_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, halted, trap};

  multicycle_controller #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .halt_req   (halt_req),
    .pc_write   (pc_write),
    .pc_write_c (pc_write_c),
    .pc_src     (pc_src),
    .i_or_d     (i_or_d),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .reg_dst    (reg_dst),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .halted     (halted),
    .trap       (trap),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1);
  end

  function automatic logic [17:0] cw(input logic pcw, input logic pcwc, input logic [1:0] pcs,
                                     input logic iord, input logic irw, input logic mr,
                                     input logic mw, input logic m2r, input logic rdst,
                                     input logic rw, input logic asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic h, input logic t);
    return {pcw, pcwc, pcs, iord, irw, mr, mw, m2r, rdst, rw, asa, asb, aop, h, t};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the control word mid-cycle, then advance to the next falling edge
  task automatic step(input string tag, input logic [17:0] exp);
    #1;
    chk(tag, {14'd0, word}, {14'd0, exp});
    @(negedge clk);
  endtask

  logic [17:0] W_ZERO, W_FWAIT, W_FACK, W_DECODE, W_MEMADR, W_MEMRD, W_MEMWB, W_MEMWR;
  logic [17:0] W_EXEC, W_RWB, W_ADDI_EX, W_ADDI_WB, W_BRANCH, W_JUMP, W_HALT, W_TRAP;

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b0; halt_req = 1'b0;

    W_ZERO    = '0;
    W_FWAIT   = cw(0,0,2'd0,0,0,1,0,0,0,0,0,2'd1,2'd0,0,0);
    W_FACK    = cw(1,0,2'd0,0,1,1,0,0,0,0,0,2'd1,2'd0,0,0);
    W_DECODE  = cw(0,0,2'd0,0,0,0,0,0,0,0,0,2'd3,2'd0,0,0);
    W_MEMADR  = cw(0,0,2'd0,0,0,0,0,0,0,0,1,2'd2,2'd0,0,0);
    W_MEMRD   = cw(0,0,2'd0,1,0,1,0,0,0,0,0,2'd0,2'd0,0,0);
    W_MEMWB   = cw(0,0,2'd0,0,0,0,0,1,0,1,0,2'd0,2'd0,0,0);
    W_MEMWR   = cw(0,0,2'd0,1,0,0,1,0,0,0,0,2'd0,2'd0,0,0);
    W_EXEC    = cw(0,0,2'd0,0,0,0,0,0,0,0,1,2'd0,2'd2,0,0);
    W_RWB     = cw(0,0,2'd0,0,0,0,0,0,1,1,0,2'd0,2'd0,0,0);
    W_ADDI_EX = cw(0,0,2'd0,0,0,0,0,0,0,0,1,2'd2,2'd0,0,0);
    W_ADDI_WB = cw(0,0,2'd0,0,0,0,0,0,0,1,0,2'd0,2'd0,0,0);
    W_BRANCH  = cw(0,1,2'd1,0,0,0,0,0,0,0,1,2'd0,2'd1,0,0);
    W_JUMP    = cw(1,0,2'd2,0,0,0,0,0,0,0,0,2'd0,2'd0,0,0);
    W_HALT    = cw(0,0,2'd0,0,0,0,0,0,0,0,0,2'd0,2'd0,1,0);
    W_TRAP    = cw(0,0,2'd0,0,0,0,0,0,0,0,0,2'd0,2'd0,0,1);

    repeat (2) @(negedge clk);
    #1;
    chk("reset_word", {14'd0, word}, {14'd0, W_ZERO});
    chk("reset_retired", retired, 32'd0);
    reset = 1'b1;

    // R-type
    step("rt_fetch_wait", W_FWAIT);
    mem_ready = 1'b1; opcode = 6'h00;
    step("rt_fetch", W_FACK);
    step("rt_decode", W_DECODE);
    step("rt_exec", W_EXEC);
    step("rt_rwb", W_RWB);
    chk("rt_retired", retired, 32'd1);

    // lw with 3 wait cycles in MEMRD
    opcode = 6'h23;
    step("lw_fetch", W_FACK);
    step("lw_decode", W_DECODE);
    step("lw_memadr", W_MEMADR);
    mem_ready = 1'b0;
    repeat (3) step("lw_memrd_wait", W_MEMRD);
    mem_ready = 1'b1;
    step("lw_memrd_done", W_MEMRD);
    step("lw_memwb", W_MEMWB);
    chk("lw_retired", retired, 32'd2);

    // beq taken and not taken
    opcode = 6'h04; zero = 1'b1;
    step("beq1_fetch", W_FACK);
    step("beq1_decode", W_DECODE);
    step("beq1_branch", W_BRANCH);
    chk("beq1_retired", retired, 32'd3);
    zero = 1'b0;
    step("beq0_fetch", W_FACK);
    step("beq0_decode", W_DECODE);
    step("beq0_branch", W_BRANCH);
    chk("beq0_retired", retired, 32'd4);

    opcode = 6'h08;
    step("addi_fetch", W_FACK);
    step("addi_decode", W_DECODE);
    step("addi_ex", W_ADDI_EX);
    step("addi_wb", W_ADDI_WB);
    chk("addi_retired", retired, 32'd5);

    opcode = 6'h02;
    step("j_fetch", W_FACK);
    step("j_decode", W_DECODE);
    step("j_jump", W_JUMP);
    chk("j_retired", retired, 32'd6);

    // mem_ready arriving on the last allowed wait cycle beats the timeout
    opcode = 6'h23;
    step("lw2_fetch", W_FACK);
    step("lw2_decode", W_DECODE);
    step("lw2_memadr", W_MEMADR);
    mem_ready = 1'b0;
    repeat (14) step("lw2_memrd_wait", W_MEMRD);
    mem_ready = 1'b1;
    step("lw2_memrd_edge", W_MEMRD);
    step("lw2_memwb", W_MEMWB);
    chk("lw2_retired", retired, 32'd7);

    // halt requested mid-instruction takes effect at the next FETCH
    opcode = 6'h00;
    step("h_fetch", W_FACK);
    step("h_decode", W_DECODE);
    halt_req = 1'b1;
    step("h_exec", W_EXEC);
    step("h_rwb", W_RWB);
    chk("h_retired", retired, 32'd8);
    step("h_fetch_halt", W_FWAIT);
    step("h_halt1", W_HALT);
    halt_req = 1'b0;
    step("h_halt2", W_HALT);

    // sw with mem_ready never asserted
    opcode = 6'h2B; mem_ready = 1'b1;
    step("sw_fetch", W_FACK);
    step("sw_decode", W_DECODE);
    step("sw_memadr", W_MEMADR);
    mem_ready = 1'b0;
    repeat (15) step("sw_memwr_wait", W_MEMWR);
    for (int i = 0; i < 20; i++) begin
      halt_req = i[0]; mem_ready = i[1];
      step("sw_trap", W_TRAP);
    end
    halt_req = 1'b0; mem_ready = 1'b0;
    chk("sw_trap_retired", retired, 32'd8);

    reset = 1'b0;
    #1;
    chk("reset2_word", {14'd0, word}, {14'd0, W_ZERO});
    chk("reset2_retired", retired, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // illegal opcode
    opcode = 6'h3F; mem_ready = 1'b1;
    step("ill_fetch", W_FACK);
    step("ill_decode", W_DECODE);
    repeat (20) step("ill_trap", W_TRAP);
    chk("ill_retired", retired, 32'd0);

    // asynchronous reset during a pending write drops the strobe at once
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; opcode = 6'h2B; mem_ready = 1'b1;
    step("rst_sw_fetch", W_FACK);
    step("rst_sw_decode", W_DECODE);
    mem_ready = 1'b0;
    step("rst_sw_memadr", W_MEMADR);
    #1;
    chk("rst_sw_memwr", {14'd0, word}, {14'd0, W_MEMWR});
    reset = 1'b0;
    #1;
    chk("rst_sw_dropped", {14'd0, word}, {14'd0, W_ZERO});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
